mc_ctrl: RTL and testbench

//  Multicycle control FSM; the driving end of the IFU fetch/next-PC interface.

---
 rtl/mc_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM driving the IFU fetch/next-PC interface
// Sequences fetch/decode/exec/mem/writeback and counts retired instructions.
module mc_ctrl #(
  parameter int CNT_W          = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       NPCSel,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             ExtOp,
  output logic             MemWr,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_REG  = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_BEQ  = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal;
  logic       is_rtype, is_legal;
  logic [1:0] alu_op_c;
  logic       alu_src_c;
  logic       ext_op_c;

  // Only opcode and funct steer control; register and immediate fields belong to the datapath.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr[25:6];

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    is_addu  = (op == 6'h00) && (funct == 6'h21);
    is_subu  = (op == 6'h00) && (funct == 6'h23);
    is_jr    = (op == 6'h00) && (funct == 6'h08);
    is_ori   = (op == 6'h0D);
    is_lui   = (op == 6'h0F);
    is_lw    = (op == 6'h23);
    is_sw    = (op == 6'h2B);
    is_beq   = (op == 6'h04);
    is_j     = (op == 6'h02);
    is_jal   = (op == 6'h03);
    is_rtype = is_addu || is_subu;
    is_legal = is_addu || is_subu || is_jr || is_ori || is_lui ||
               is_lw || is_sw || is_beq || is_j || is_jal;
  end

  always_comb begin
    alu_op_c  = 2'b00;
    alu_src_c = 1'b0;
    ext_op_c  = 1'b0;
    if (is_subu || is_beq) begin
      alu_op_c = 2'b01;
    end else if (is_ori) begin
      alu_op_c = 2'b10;
    end else if (is_lui) begin
      alu_op_c = 2'b11;
    end
    alu_src_c = is_ori || is_lui || is_lw || is_sw;
    ext_op_c  = is_lw || is_sw || is_beq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_j || is_jal || is_jr) begin
          state_d = S_FETCH;
        end else if (!is_legal) begin
          state_d = ILLEGAL_AS_NOP ? S_FETCH : S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an aborted instruction never leaks a write.
  always_comb begin
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    NPCSel  = NPC_SEQ;
    RegWr   = 1'b0;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    ALUSrc  = 1'b0;
    ALUOp   = 2'b00;
    ExtOp   = 1'b0;
    MemWr   = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: IRWr = 1'b1;
        S_DECODE: begin
          if (is_j || is_jal) begin
            PCWr   = 1'b1;
            NPCSel = NPC_JMP;
          end
          if (is_jal) begin
            RegWr  = 1'b1;
            RegDst = 2'b10;
            WDSel  = 2'b10;
          end
          if (is_jr) begin
            PCWr   = 1'b1;
            NPCSel = NPC_REG;
          end
          if (!is_legal) begin
            illegal = 1'b1;
            PCWr    = ILLEGAL_AS_NOP;
          end
        end
        S_EXEC: begin
          ALUOp  = alu_op_c;
          ALUSrc = alu_src_c;
          ExtOp  = ext_op_c;
          if (is_beq) begin
            PCWr   = 1'b1;
            NPCSel = zero ? NPC_BEQ : NPC_SEQ;
          end
        end
        S_MEM: begin
          ALUOp  = alu_op_c;
          ALUSrc = alu_src_c;
          ExtOp  = ext_op_c;
          if (mem_ready && is_sw) begin
            MemWr = 1'b1;
            PCWr  = 1'b1;
          end
        end
        S_WB: begin
          ALUOp  = alu_op_c;
          ALUSrc = alu_src_c;
          ExtOp  = ext_op_c;
          RegWr  = 1'b1;
          PCWr   = 1'b1;
          RegDst = is_rtype ? 2'b01 : 2'b00;
          WDSel  = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (PCWr) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl
// Random instruction stream against a per-instruction reference model, plus directed corner cases.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, zero, mem_ready;
  logic [31:0] instr;
  logic        IRWr, PCWr, RegWr, ALUSrc, ExtOp, MemWr, illegal;
  logic [1:0]  NPCSel, RegDst, WDSel, ALUOp;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        reset_h;
  logic [31:0] instr_h;
  logic        IRWr_h, PCWr_h, RegWr_h, ALUSrc_h, ExtOp_h, MemWr_h, illegal_h;
  logic [1:0]  NPCSel_h, RegDst_h, WDSel_h, ALUOp_h;
  logic [2:0]  state_h;
  logic [2:0]  retired_h;

  mc_ctrl #(.CNT_W(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .IRWr(IRWr), .PCWr(PCWr), .NPCSel(NPCSel), .RegWr(RegWr), .RegDst(RegDst),
    .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ExtOp(ExtOp), .MemWr(MemWr),
    .illegal(illegal), .state(state), .retired(retired)
  );

  mc_ctrl #(.CNT_W(3), .ILLEGAL_AS_NOP(1'b0)) dut_h (
    .clk(clk), .reset(reset_h), .instr(instr_h), .zero(zero), .mem_ready(mem_ready),
    .IRWr(IRWr_h), .PCWr(PCWr_h), .NPCSel(NPCSel_h), .RegWr(RegWr_h), .RegDst(RegDst_h),
    .WDSel(WDSel_h), .ALUSrc(ALUSrc_h), .ALUOp(ALUOp_h), .ExtOp(ExtOp_h), .MemWr(MemWr_h),
    .illegal(illegal_h), .state(state_h), .retired(retired_h)
  );

  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4, C_LW = 5;
  localparam int C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

  typedef struct {
    int         lat;
    logic [1:0] npc;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       memwr;
    logic       ill;
    bit         alu_chk;
    logic [1:0] aluop;
    logic       alusrc;
    bit         ext_chk;
    logic       extop;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  int   n_issued = 0;
  int   cyc = 0;
  bit   ill_seen = 1'b0;
  bit   mon_en = 1'b0;
  bit   watch = 1'b0;
  int   memwr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int cls, input bit z, input int w);
    exp_t e;
    e = '{lat: 4, npc: 2'b00, regwr: 1'b0, regdst: 2'b00, wdsel: 2'b00, memwr: 1'b0,
          ill: 1'b0, alu_chk: 1'b0, aluop: 2'b00, alusrc: 1'b0, ext_chk: 1'b0,
          extop: 1'b0, idx: 0};
    case (cls)
      C_J:    begin e.lat = 2; e.npc = 2'b10; end
      C_JAL:  begin e.lat = 2; e.npc = 2'b10; e.regwr = 1; e.regdst = 2'b10; e.wdsel = 2'b10; end
      C_JR:   begin e.lat = 2; e.npc = 2'b01; end
      C_ILL:  begin e.lat = 2; e.ill = 1; end
      C_BEQ:  begin e.lat = 3; e.npc = z ? 2'b11 : 2'b00; e.alu_chk = 1; e.aluop = 2'b01;
                    e.ext_chk = 1; e.extop = 1; end
      C_ADDU: begin e.regwr = 1; e.regdst = 2'b01; e.alu_chk = 1; e.aluop = 2'b00; end
      C_SUBU: begin e.regwr = 1; e.regdst = 2'b01; e.alu_chk = 1; e.aluop = 2'b01; end
      C_ORI:  begin e.regwr = 1; e.alu_chk = 1; e.aluop = 2'b10; e.alusrc = 1;
                    e.ext_chk = 1; e.extop = 0; end
      C_LUI:  begin e.regwr = 1; e.alu_chk = 1; e.aluop = 2'b11; e.alusrc = 1; end
      C_LW:   begin e.lat = 5 + w; e.regwr = 1; e.wdsel = 2'b01; e.alu_chk = 1; e.alusrc = 1;
                    e.ext_chk = 1; e.extop = 1; end
      C_SW:   begin e.lat = 4 + w; e.memwr = 1; e.alu_chk = 1; e.alusrc = 1;
                    e.ext_chk = 1; e.extop = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit known(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h08);
    return (op == 6'h0D) || (op == 6'h0F) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h03);
  endfunction

  function automatic logic [31:0] build(input int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      C_ADDU: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
      C_SUBU: begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
      C_JR:   begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      C_ORI:  r[31:26] = 6'h0D;
      C_LUI:  r[31:26] = 6'h0F;
      C_LW:   r[31:26] = 6'h23;
      C_SW:   r[31:26] = 6'h2B;
      C_BEQ:  r[31:26] = 6'h04;
      C_J:    r[31:26] = 6'h02;
      C_JAL:  r[31:26] = 6'h03;
      default: begin
        while (known(r[31:26], r[5:0])) r = $urandom;
      end
    endcase
    return r;
  endfunction

  // Called with the DUT in FETCH, one posedge+1 into the cycle; returns at the next FETCH.
  task automatic issue(input logic [31:0] ins, input int cls, input bit z, input int w);
    exp_t e;
    int   memcnt;
    bit   done;
    chk("start_in_fetch", {29'd0, state}, 32'd0);
    e = model(cls, z, w);
    e.idx = n_issued;
    n_issued++;
    q.push_back(e);
    instr = ins;
    zero = z;
    mem_ready = 1'($urandom);
    memcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (state == 3'd3) begin
        mem_ready = (memcnt >= w);
        memcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      if (state == 3'd0) done = 1'b1;
    end
    chk("instr_completes", {31'd0, done}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (state == 3'd0) begin
        cyc = 1;
        ill_seen = 1'b0;
        chk("fetch_irwr", {31'd0, IRWr}, 32'd1);
      end else begin
        cyc++;
      end
      if (illegal) ill_seen = 1'b1;
      if ((MemWr || RegWr) && !PCWr) chk("write_without_pcwr", {31'd0, PCWr}, 32'd1);
      if (state == 3'd2) begin
        chk("exec_queue", q.size(), 32'd1);
        if (q.size() > 0) begin
          me = q[0];
          if (me.alu_chk) begin
            chk("exec_aluop", {30'd0, ALUOp}, {30'd0, me.aluop});
            chk("exec_alusrc", {31'd0, ALUSrc}, {31'd0, me.alusrc});
          end
          if (me.ext_chk) chk("exec_extop", {31'd0, ExtOp}, {31'd0, me.extop});
        end
      end
      if (PCWr) begin
        chk("pcwr_queue", q.size(), 32'd1);
        if (q.size() > 0) begin
          me = q.pop_front();
          chk("latency", cyc, me.lat);
          chk("npcsel", {30'd0, NPCSel}, {30'd0, me.npc});
          chk("regwr", {31'd0, RegWr}, {31'd0, me.regwr});
          if (me.regwr) begin
            chk("regdst", {30'd0, RegDst}, {30'd0, me.regdst});
            chk("wdsel", {30'd0, WDSel}, {30'd0, me.wdsel});
          end
          chk("memwr", {31'd0, MemWr}, {31'd0, me.memwr});
          chk("illegal", {31'd0, ill_seen}, {31'd0, me.ill});
          chk("retired_before", retired, me.idx);
        end
      end
    end
  end

  always @(MemWr) begin
    if (watch && MemWr === 1'b1) memwr_cnt++;
  end

  initial begin
    int cls;
    reset = 1'b1; instr = 'x; zero = 1'b0; mem_ready = 1'b0;
    reset_h = 1'b1; instr_h = 'x;

    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_irwr", {31'd0, IRWr}, 32'd0);
    chk("rst_pcwr", {31'd0, PCWr}, 32'd0);
    chk("rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("rst_memwr", {31'd0, MemWr}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_state", {29'd0, state}, 32'd0);
    chk("post_rst_irwr", {31'd0, IRWr}, 32'd1);
    chk("post_rst_retired", retired, 32'd0);
    mon_en = 1'b1;

    issue(32'h00851021, C_ADDU, 1'b0, 0);
    issue(32'h8D280004, C_LW, 1'b0, 2);
    issue(32'h10220003, C_BEQ, 1'b1, 0);
    issue(32'h10220003, C_BEQ, 1'b0, 0);
    issue(32'h0C000042, C_JAL, 1'b0, 0);
    issue(32'h03E00008, C_JR, 1'b0, 0);
    issue(32'hFC000000, C_ILL, 1'b0, 0);
    issue(32'hAD280004, C_SW, 1'b0, 0);
    for (int i = 0; i < 200; i++) begin
      cls = int'($urandom_range(0, 10));
      issue(build(cls), cls, 1'($urandom), int'($urandom_range(0, 3)));
    end
    chk("retired_total", retired, n_issued);
    chk("queue_drained", q.size(), 32'd0);
    mon_en = 1'b0;

    // Abort a store while it waits in MEM.
    instr = 32'hAD280004;
    mem_ready = 1'b0;
    memwr_cnt = 0;
    watch = 1'b1;
    for (int c = 0; c < 10 && state != 3'd3; c++) begin
      @(posedge clk); #1;
    end
    chk("sw_reached_mem", {29'd0, state}, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("sw_mem_hold", {29'd0, state}, 32'd3);
    #2 reset = 1'b1;
    #1 mem_ready = 1'b1;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_memwr", {31'd0, MemWr}, 32'd0);
    chk("abort_pcwr", {31'd0, PCWr}, 32'd0);
    chk("abort_retired", retired, 32'd0);
    @(posedge clk);
    @(negedge clk);
    instr = 32'h08000000;
    reset = 1'b0;
    #1;
    chk("abort_release_state", {29'd0, state}, 32'd0);
    chk("abort_release_irwr", {31'd0, IRWr}, 32'd1);
    chk("abort_memwr_count", memwr_cnt, 32'd0);
    watch = 1'b0;

    // Narrow counter wrap and HALT behaviour on the second instance.
    @(posedge clk); #1;
    instr_h = 32'h08000000;
    reset_h = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("h_retired_7", {29'd0, retired_h}, 32'd7);
    chk("h_state_fetch", {29'd0, state_h}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("h_retired_wrap", {29'd0, retired_h}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("h_retired_1", {29'd0, retired_h}, 32'd1);
    instr_h = 32'hFC000000;
    @(posedge clk); #1;
    chk("h_decode_state", {29'd0, state_h}, 32'd1);
    chk("h_illegal", {31'd0, illegal_h}, 32'd1);
    chk("h_illegal_pcwr", {31'd0, PCWr_h}, 32'd0);
    @(posedge clk); #1;
    chk("h_halt_state", {29'd0, state_h}, 32'd7);
    chk("h_halt_illegal", {31'd0, illegal_h}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("h_halt_stay", {29'd0, state_h}, 32'd7);
      chk("h_halt_pcwr", {31'd0, PCWr_h}, 32'd0);
      chk("h_halt_irwr", {31'd0, IRWr_h}, 32'd0);
    end
    chk("h_halt_retired", {29'd0, retired_h}, 32'd1);
    reset_h = 1'b1;
    #1;
    chk("h_reset_state", {29'd0, state_h}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
